// File: rtl/riscv_regfile.sv
// Integer register file: x0 reads zero, 2 combinational read ports with write-first bypass, 1 sync write, registered debug read.
// Latency: reads 0 cycles, debug 1 cycle; no backpressure. Optional parity detection under RISCV_REGFILE_PARITY_EN.
module riscv_regfile #(
    parameter int REGFILE_COUNT = 32,
    parameter int WORD_SIZE     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             reg_write_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] write_reg_i,
    input  logic [WORD_SIZE-1:0]             write_data_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] read_reg0_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] read_reg1_i,
    output logic [WORD_SIZE-1:0]             read_data0_o,
    output logic [WORD_SIZE-1:0]             read_data1_o,
    input  logic [$clog2(REGFILE_COUNT)-1:0] dbg_reg_i,
    output logic [WORD_SIZE-1:0]             dbg_data_o
`ifdef RISCV_REGFILE_PARITY_EN
   ,input  logic                             parity_clr_i,
    input  logic                             parity_inj_i,
    output logic                             parity_err_o
`endif
);

    localparam int AW = $clog2(REGFILE_COUNT);

    logic [WORD_SIZE-1:0] regs [REGFILE_COUNT];
    logic                 wr_en;
    logic                 bypass0;
    logic                 bypass1;

    assign wr_en   = reg_write_i && (write_reg_i != '0);
    assign bypass0 = wr_en && (write_reg_i == read_reg0_i);
    assign bypass1 = wr_en && (write_reg_i == read_reg1_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REGFILE_COUNT; i++) begin
                regs[i] <= '0;
            end
            dbg_data_o <= '0;
        end else begin
            // Debug sees the array as it stood before this edge's write.
            dbg_data_o <= regs[dbg_reg_i];
            if (wr_en) begin
                regs[write_reg_i] <= write_data_i;
            end
        end
    end

    always_comb begin
        read_data0_o = '0;
        if (rst_ni && (read_reg0_i != '0)) begin
            read_data0_o = bypass0 ? write_data_i : regs[read_reg0_i];
        end
    end

    always_comb begin
        read_data1_o = '0;
        if (rst_ni && (read_reg1_i != '0)) begin
            read_data1_o = bypass1 ? write_data_i : regs[read_reg1_i];
        end
    end

`ifdef RISCV_REGFILE_PARITY_EN
    logic [REGFILE_COUNT-1:0] par_q;
    logic                     par_bad0;
    logic                     par_bad1;

    // Bypassed reads never touch the array, so only stored entries are checked.
    assign par_bad0 = rst_ni && (read_reg0_i != '0) && !bypass0 &&
                      (par_q[read_reg0_i] != ^regs[read_reg0_i]);
    assign par_bad1 = rst_ni && (read_reg1_i != '0) && !bypass1 &&
                      (par_q[read_reg1_i] != ^regs[read_reg1_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q        <= '0;
            parity_err_o <= 1'b0;
        end else begin
            if (wr_en) begin
                par_q[write_reg_i] <= (^write_data_i) ^ parity_inj_i;
            end
            if (par_bad0 || par_bad1) begin
                parity_err_o <= 1'b1;
            end else if (parity_clr_i) begin
                parity_err_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_regfile.sv
// Bench for riscv_regfile: vector table for reads/bypass, queue of expected debug values, hand sequences for reset and parity.
module tb_riscv_regfile;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  write_reg_i = '0;
    logic [31:0] write_data_i = '0;
    logic [4:0]  read_reg0_i = '0;
    logic [4:0]  read_reg1_i = '0;
    logic [31:0] read_data0_o;
    logic [31:0] read_data1_o;
    logic [4:0]  dbg_reg_i = '0;
    logic [31:0] dbg_data_o;
`ifdef RISCV_REGFILE_PARITY_EN
    logic        parity_clr_i = 1'b0;
    logic        parity_inj_i = 1'b0;
    logic        parity_err_o;
`endif

    riscv_regfile #(.REGFILE_COUNT(32), .WORD_SIZE(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reg_write_i  (reg_write_i),
        .write_reg_i  (write_reg_i),
        .write_data_i (write_data_i),
        .read_reg0_i  (read_reg0_i),
        .read_reg1_i  (read_reg1_i),
        .read_data0_o (read_data0_o),
        .read_data1_o (read_data1_o),
        .dbg_reg_i    (dbg_reg_i),
        .dbg_data_o   (dbg_data_o)
`ifdef RISCV_REGFILE_PARITY_EN
       ,.parity_clr_i (parity_clr_i),
        .parity_inj_i (parity_inj_i),
        .parity_err_o (parity_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [4:0]  dbg;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          check_cnt = 0;
    int          pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] dexp;
        @(negedge clk_i);
        reg_write_i  = v.we;
        write_reg_i  = v.wreg;
        write_data_i = v.wdata;
        read_reg0_i  = v.r0;
        read_reg1_i  = v.r1;
        dbg_reg_i    = v.dbg;
        #1;
        check($sformatf("vec%0d_rd0", idx), read_data0_o, v.e0);
        check($sformatf("vec%0d_rd1", idx), read_data1_o, v.e1);
        exp_q.push_back(model[v.dbg]);
        if (v.we && v.wreg != 5'd0) model[v.wreg] = v.wdata;
        @(posedge clk_i);
        #1;
        dexp = exp_q.pop_front();
        check($sformatf("vec%0d_dbg", idx), dbg_data_o, dexp);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        //           we    wreg   wdata          r0     r1     dbg    e0             e1
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  5'd5,  32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  32'h0,         32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd7,  32'h1,        5'd7,  5'd6,  5'd7,  32'h1,         32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  5'd7,  32'hA5A5A5A5,  32'hA5A5A5A5};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  5'd7,  32'hA5A5A5A5,  32'hDEADBEEF};
        vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 5'd31, 32'h0,         32'hCAFEF00D};
        vecs[8] = '{1'b0, 5'd31, 32'h11111111, 5'd31, 5'd31, 5'd31, 32'hCAFEF00D,  32'hCAFEF00D};
        vecs[9] = '{1'b1, 5'd5,  32'h0,        5'd5,  5'd7,  5'd5,  32'h0,         32'hA5A5A5A5};

        // Reset state while held in reset.
        #12;
        check("rst_rd0", read_data0_o, 32'h0);
        check("rst_dbg", dbg_data_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fresh array: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_i);
            read_reg0_i = 5'(i);
            read_reg1_i = 5'(31 - i);
            dbg_reg_i   = 5'(i);
            #1;
            check($sformatf("init_rd0_x%0d", i), read_data0_o, 32'h0);
            check($sformatf("init_rd1_x%0d", 31 - i), read_data1_o, 32'h0);
        end
        @(posedge clk_i);
        #1;
        check("init_dbg", dbg_data_o, 32'h0);

        for (int i = 0; i < 10; i++) apply(vecs[i], i);

        // Reset asserted mid-cycle after x31 is written.
        @(negedge clk_i);
        reg_write_i  = 1'b1;
        write_reg_i  = 5'd31;
        write_data_i = 32'hFFFFFFFF;
        read_reg0_i  = 5'd31;
        read_reg1_i  = 5'd7;
        dbg_reg_i    = 5'd31;
        @(negedge clk_i);
        reg_write_i = 1'b0;
        #1;
        check("pre_rst_x31", read_data0_o, 32'hFFFFFFFF);
        @(posedge clk_i);
        #1;
        check("pre_rst_dbg", dbg_data_o, 32'hFFFFFFFF);
        reg_write_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_rd0", read_data0_o, 32'h0);
        check("rst_async_rd1", read_data1_o, 32'h0);
        check("rst_async_dbg", dbg_data_o, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_hold_rd0", read_data0_o, 32'h0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        reg_write_i = 1'b0;
        #1;
        check("post_rst_x31", read_data0_o, 32'h0);
        check("post_rst_x7", read_data1_o, 32'h0);
        @(posedge clk_i);
        #1;
        check("post_rst_dbg", dbg_data_o, 32'h0);

`ifdef RISCV_REGFILE_PARITY_EN
        check("par_reset", {31'h0, parity_err_o}, 32'h0);
        @(negedge clk_i);
        reg_write_i  = 1'b1;
        write_reg_i  = 5'd9;
        write_data_i = 32'h3;
        parity_inj_i = 1'b1;
        read_reg0_i  = 5'd9;
        read_reg1_i  = 5'd0;
        @(posedge clk_i);
        #1;
        check("par_bypass_noerr", {31'h0, parity_err_o}, 32'h0);
        @(negedge clk_i);
        reg_write_i  = 1'b0;
        parity_inj_i = 1'b0;
        #1;
        check("par_rd_data", read_data0_o, 32'h3);
        @(posedge clk_i);
        #1;
        check("par_err_set", {31'h0, parity_err_o}, 32'h1);
        @(negedge clk_i);
        read_reg0_i = 5'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("par_err_sticky", {31'h0, parity_err_o}, 32'h1);
        @(negedge clk_i);
        read_reg1_i  = 5'd9;
        parity_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("par_set_wins", {31'h0, parity_err_o}, 32'h1);
        @(negedge clk_i);
        read_reg1_i = 5'd0;
        @(posedge clk_i);
        #1;
        check("par_clr", {31'h0, parity_err_o}, 32'h0);
        @(negedge clk_i);
        parity_clr_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
